// File: rtl/bcd_updown_counter_if.sv
// Button inputs and BCD digit outputs of the two-digit up/down counter.
// The master drives the raw buttons and hold; the slave (counter) drives the digits.
interface bcd_updown_counter_if;
    logic       btn_up;
    logic       btn_down;
    logic       hold;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap;

    modport master (
        output btn_up,
        output btn_down,
        output hold,
        input  ones,
        input  tens,
        input  wrap
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  hold,
        output ones,
        output tens,
        output wrap
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter fed by two raw active-low push-buttons.
// Each button is synchronised and debounced, and each clean press steps the count once.
module bcd_updown_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_updown_counter_if.slave  bus
);
    localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    // Index 0 = up button, index 1 = down button.
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    deb_prev_q;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    press;

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       wrap_q, wrap_d;
    logic       up_ev, down_ev;

    assign raw = {bus.btn_down, bus.btn_up};

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is the debounced 1->0 edge; releases are ignored.
    assign press   = deb_prev_q & ~deb_q;
    assign up_ev   = press[0] & ~press[1] & ~bus.hold;
    assign down_ev = press[1] & ~press[0] & ~bus.hold;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (up_ev) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else if (tens_q < 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = '0;
                tens_d = '0;
                wrap_d = 1'b1;
            end
        end else if (down_ev) begin
            if (ones_q > 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if (tens_q > 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                tens_d = 4'd9;
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            ones_q     <= '0;
            tens_q     <= '0;
            wrap_q     <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.ones = ones_q;
    assign bus.tens = tens_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DEBOUNCE_CYCLES=4 (press latency E+7).
// Observed value is packed as {wrap, tens, ones}.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    bcd_updown_counter_if bus ();

    bcd_updown_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.wrap, bus.tens, bus.ones};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press_up();
        bus.btn_up = 1'b0;
        step(10);
        bus.btn_up = 1'b1;
        step(10);
    endtask

    task automatic press_down();
        bus.btn_down = 1'b0;
        step(10);
        bus.btn_down = 1'b1;
        step(10);
    endtask

    initial begin
        reset        = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.hold     = 1'b0;

        // 1: reset with both buttons held, then simultaneous presses cancel
        step(2);
        chk("reset_state", 9'h000);
        reset = 1'b0;
        step(7);
        chk("both_e6", 9'h000);
        step(1);
        chk("both_e7", 9'h000);
        step(5);
        chk("both_after", 9'h000);
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        step(10);
        chk("both_release", 9'h000);

        // 2: exact press latency, single step while held, second press
        bus.btn_up = 1'b0;
        step(7);
        chk("up_lat_e6", 9'h000);
        step(1);
        chk("up_lat_e7", 9'h001);
        step(1);
        chk("up_lat_e8", 9'h001);
        step(12);
        chk("up_held", 9'h001);
        bus.btn_up = 1'b1;
        step(10);
        chk("up_release", 9'h001);
        press_up();
        chk("up_second", 9'h002);

        // 3: bounce shorter than the debounce window is rejected
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) bus.btn_up = ~bus.btn_up;
            step(1);
            chk("bounce", 9'h002);
        end
        bus.btn_up = 1'b1;
        step(10);
        chk("bounce_after", 9'h002);

        // 4: digit carry/borrow and wrap in both directions
        for (int i = 0; i < 7; i++) press_up();
        chk("preload_09", 9'h009);
        press_up();
        chk("carry_10", 9'h010);
        press_down();
        chk("borrow_09", 9'h009);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        chk("reset_00", 9'h000);
        bus.btn_down = 1'b0;
        step(7);
        chk("down_wrap_e6", 9'h000);
        step(1);
        chk("down_wrap_e7", 9'h199);
        step(1);
        chk("down_wrap_e8", 9'h099);
        bus.btn_down = 1'b1;
        step(10);
        bus.btn_up = 1'b0;
        step(8);
        chk("up_wrap_e7", 9'h100);
        step(1);
        chk("up_wrap_e8", 9'h000);
        bus.btn_up = 1'b1;
        step(10);
        chk("up_wrap_after", 9'h000);

        // 5: press during hold is dropped, not deferred
        bus.hold = 1'b1;
        press_up();
        bus.hold = 1'b0;
        step(10);
        chk("hold_drop", 9'h000);
        press_up();
        chk("hold_released_up", 9'h001);

        // 6: reset mid-debounce discards the press
        bus.btn_up = 1'b0;
        step(5);
        reset      = 1'b1;
        bus.btn_up = 1'b1;
        step(1);
        chk("midreset", 9'h000);
        step(1);
        reset = 1'b0;
        step(12);
        chk("midreset_after", 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
